// File: rtl/pid_regbank_sequencer.sv
// Staging/active register bank between the I2C slave RAM port and the PID core.
// A commit-key write arms a copy; the copy runs one register per cycle from the next core loop-boundary sync.
module pid_regbank_sequencer #(
    parameter logic [7:0] BASE_ADDR  = 8'h40,
    parameter int         NUM_REGS   = 20,
    parameter logic [7:0] COMMIT_KEY = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i2c_wr,
    input  logic [7:0]                i2c_index,
    input  logic [7:0]                i2c_wdata,
    output logic [7:0]                i2c_rdata,
    input  logic                      core_req,
    input  logic                      core_we,
    input  logic [7:0]                core_addr,
    input  logic [7:0]                core_wdata,
    output logic                      core_gnt,
    output logic [7:0]                core_rdata,
    input  logic                      core_sync,
    output logic [8*(NUM_REGS-1)-1:0] active_regs,
    output logic                      busy,
    output logic                      commit_done,
    output logic                      oor_err
);

    localparam int             ND       = NUM_REGS - 1;
    localparam int             IW       = $clog2(NUM_REGS);
    localparam logic [7:0]     CTRL_OFS = 8'(NUM_REGS - 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(ND - 1);

    localparam logic [1:0] DEC_DATA = 2'd0;
    localparam logic [1:0] DEC_CTRL = 2'd1;
    localparam logic [1:0] DEC_OOR  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COPY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ND-1:0][7:0]   staging;
    logic [ND-1:0][7:0]   staging_nxt;
    logic [ND-1:0][7:0]   active;
    logic [7:0]           ctrl_reg;
    logic [7:0]           ctrl_nxt;
    logic                 oor_nxt;
    logic                 wr_q;
    logic [IW-1:0]        copy_idx;
    logic                 pend_vld;
    logic [7:0]           pend_addr;
    logic [7:0]           pend_dat;

    logic                 i2c_edge;
    logic                 port_open;
    logic                 core_take;
    logic [1:0]           state_code;
    logic [7:0]           core_rd_val;
    logic [7:0]           w_ofs;

    // Write ports, applied in order: pending latch, direct I2C, core.
    logic                 wen [3];
    logic [7:0]           wad [3];
    logic [7:0]           wdt [3];

    function automatic logic [1:0] dec(input logic [7:0] a);
        logic [7:0] o;
        o = a - BASE_ADDR;
        dec = DEC_OOR;
        if (a >= BASE_ADDR) begin
            if (o < 8'(ND))
                dec = DEC_DATA;
            else if (o == CTRL_OFS)
                dec = DEC_CTRL;
        end
    endfunction

    function automatic logic [7:0] rd_val(input logic [7:0] a,
                                          input logic [ND-1:0][7:0] bank,
                                          input logic [1:0] code);
        logic [7:0] o;
        o = a - BASE_ADDR;
        rd_val = 8'h00;
        case (dec(a))
            DEC_DATA: rd_val = bank[o[IW-1:0]];
            DEC_CTRL: rd_val = {6'b0, code};
            default:  rd_val = 8'h00;
        endcase
    endfunction

    assign i2c_edge    = i2c_wr & ~wr_q;
    assign port_open   = (state == IDLE) || (state == ARMED);
    // A grant already in flight blocks re-granting the still-held request.
    assign core_take   = core_req & ~core_gnt & port_open & ~i2c_edge;
    assign state_code  = (state == IDLE) ? 2'd0 : (state == ARMED) ? 2'd1 : 2'd2;
    assign i2c_rdata   = rd_val(i2c_index, staging, state_code);
    assign core_rd_val = rd_val(core_addr, staging, state_code);
    assign active_regs = active;

    always_comb begin
        wen[0] = (state == DONE) && pend_vld;
        wad[0] = pend_addr;
        wdt[0] = pend_dat;
        wen[1] = i2c_edge && (state != COPY);
        wad[1] = i2c_index;
        wdt[1] = i2c_wdata;
        wen[2] = core_take && core_we;
        wad[2] = core_addr;
        wdt[2] = core_wdata;
    end

    always_comb begin
        staging_nxt = staging;
        ctrl_nxt    = ctrl_reg;
        oor_nxt     = oor_err;
        w_ofs       = 8'h00;
        if (state == DONE)
            ctrl_nxt = 8'h00;
        for (int p = 0; p < 3; p++) begin
            if (wen[p]) begin
                w_ofs = wad[p] - BASE_ADDR;
                case (dec(wad[p]))
                    DEC_DATA: staging_nxt[w_ofs[IW-1:0]] = wdt[p];
                    DEC_CTRL: if (p != 2) ctrl_nxt = wdt[p];
                    default:  oor_nxt = 1'b1;
                endcase
            end
        end
        // Only one write can be held across a copy; a second one clobbers it.
        if ((state == COPY) && i2c_edge && pend_vld)
            oor_nxt = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctrl_reg == COMMIT_KEY) state_nxt = ARMED;
            ARMED:   if (core_sync) state_nxt = COPY;
            COPY:    if (copy_idx == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            staging     <= '0;
            active      <= '0;
            ctrl_reg    <= '0;
            wr_q        <= 1'b1;
            copy_idx    <= '0;
            pend_vld    <= 1'b0;
            pend_addr   <= '0;
            pend_dat    <= '0;
            core_gnt    <= 1'b0;
            core_rdata  <= '0;
            commit_done <= 1'b0;
            busy        <= 1'b0;
            oor_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            staging     <= staging_nxt;
            ctrl_reg    <= ctrl_nxt;
            oor_err     <= oor_nxt;
            wr_q        <= i2c_wr;
            core_gnt    <= core_take;
            busy        <= (state_nxt != IDLE);
            commit_done <= (state == COPY) && (copy_idx == LAST_IDX);

            if (core_take && !core_we)
                core_rdata <= core_rd_val;

            if ((state == ARMED) && core_sync)
                copy_idx <= '0;
            else if (state == COPY) begin
                active[copy_idx] <= staging[copy_idx];
                copy_idx         <= copy_idx + 1'b1;
            end

            if ((state == COPY) && i2c_edge) begin
                pend_vld  <= 1'b1;
                pend_addr <= i2c_index;
                pend_dat  <= i2c_wdata;
            end else if (state == DONE) begin
                pend_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pid_regbank_sequencer.sv
// Directed bench for pid_regbank_sequencer: I2C/core access, commit sequencing, reset mid-copy.
module tb_pid_regbank_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         i2c_wr;
    logic [7:0]   i2c_index;
    logic [7:0]   i2c_wdata;
    logic [7:0]   i2c_rdata;
    logic         core_req;
    logic         core_we;
    logic [7:0]   core_addr;
    logic [7:0]   core_wdata;
    logic         core_gnt;
    logic [7:0]   core_rdata;
    logic         core_sync;
    logic [151:0] active_regs;
    logic         busy;
    logic         commit_done;
    logic         oor_err;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   v;
    int           lat;
    int           cnt;

    always #5 clk = ~clk;

    pid_regbank_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .i2c_wr      (i2c_wr),
        .i2c_index   (i2c_index),
        .i2c_wdata   (i2c_wdata),
        .i2c_rdata   (i2c_rdata),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rdata  (core_rdata),
        .core_sync   (core_sync),
        .active_regs (active_regs),
        .busy        (busy),
        .commit_done (commit_done),
        .oor_err     (oor_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] val);
        i2c_index = a;
        #1;
        val = i2c_rdata;
    endtask

    task automatic i2c_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        i2c_index = a;
        i2c_wdata = d;
        i2c_wr    = 1'b1;
        @(negedge clk);
        i2c_wr    = 1'b0;
    endtask

    // Returns with core_sync low in the first COPY cycle.
    task automatic sync_pulse();
        @(negedge clk);
        core_sync = 1'b1;
        @(negedge clk);
        core_sync = 1'b0;
    endtask

    task automatic wait_commit(output int l);
        l = -1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (commit_done) begin
                l = j;
                break;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        i2c_wr     = 1'b1;
        i2c_index  = 8'h40;
        i2c_wdata  = 8'h99;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = 8'h00;
        core_wdata = 8'h00;
        core_sync  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_busy", busy, 0);
        chk("rst_oor", oor_err, 0);
        chk("rst_active", (active_regs == '0), 1);
        chk("rst_gnt", core_gnt, 0);
        chk("rst_done", commit_done, 0);
        chk("rst_rdata", core_rdata, 8'h00);

        // i2c_wr already high at release must not write
        rst = 1'b0;
        repeat (2) @(negedge clk);
        i2c_wr = 1'b0;
        @(negedge clk);
        peek(8'h40, v);
        chk("wr_high_at_release", v, 8'h00);

        // Held level writes exactly once; data changed mid-hold must not land
        @(negedge clk);
        i2c_index = 8'h42;
        i2c_wdata = 8'h3C;
        i2c_wr    = 1'b1;
        @(negedge clk);
        i2c_wdata = 8'h11;
        repeat (4) @(negedge clk);
        i2c_wr = 1'b0;
        peek(8'h42, v);
        chk("stage2_once", v, 8'h3C);
        chk("active_zero", (active_regs == '0), 1);

        // Arm, write in ARMED, commit
        i2c_write(8'h53, 8'hA5);
        i2c_write(8'h40, 8'h11);
        repeat (10) @(negedge clk);
        chk("armed_busy", busy, 1);
        peek(8'h53, v);
        chk("ctrl_armed", v, 8'h01);
        chk("armed_active_hold", active_regs[7:0], 8'h00);
        sync_pulse();
        chk("copy_busy", busy, 1);
        peek(8'h53, v);
        chk("ctrl_copy", v, 8'h02);
        wait_commit(lat);
        chk("commit_latency", lat, 19);
        chk("active2", active_regs[23:16], 8'h3C);
        chk("active0_armed_wr", active_regs[7:0], 8'h11);
        @(negedge clk);
        chk("done_one_pulse", commit_done, 0);
        chk("idle_busy", busy, 0);
        peek(8'h53, v);
        chk("ctrl_cleared", v, 8'h00);

        // Wrong key does not arm
        i2c_write(8'h53, 8'h5A);
        repeat (2) @(negedge clk);
        sync_pulse();
        repeat (3) @(negedge clk);
        chk("badkey_busy", busy, 0);
        peek(8'h53, v);
        chk("badkey_ctrl", v, 8'h00);

        // Core read collides with I2C write edge: I2C first, grant one cycle late
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 8'h42;
        i2c_index = 8'h45;
        i2c_wdata = 8'h5E;
        i2c_wr    = 1'b1;
        @(negedge clk);
        chk("collide_no_gnt", core_gnt, 0);
        @(negedge clk);
        chk("collide_gnt", core_gnt, 1);
        chk("collide_rdata", core_rdata, 8'h3C);
        core_req = 1'b0;
        i2c_wr   = 1'b0;
        @(negedge clk);
        chk("gnt_pulse", core_gnt, 0);
        peek(8'h45, v);
        chk("i2c_won", v, 8'h5E);

        // Core write, then core write of key to control is granted but ignored
        @(negedge clk);
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 8'h43;
        core_wdata = 8'h21;
        @(negedge clk);
        chk("core_wr_gnt", core_gnt, 1);
        core_addr  = 8'h53;
        core_wdata = 8'hA5;
        @(negedge clk);
        chk("core_wr_gnt_gap", core_gnt, 0);
        @(negedge clk);
        chk("core_ctrl_gnt", core_gnt, 1);
        core_req = 1'b0;
        peek(8'h43, v);
        chk("core_wr_data", v, 8'h21);
        repeat (3) @(negedge clk);
        chk("core_ctrl_noarm", busy, 0);

        // Write during COPY is held and applied in DONE
        i2c_write(8'h41, 8'h33);
        i2c_write(8'h52, 8'hE7);
        i2c_write(8'h53, 8'hA5);
        repeat (3) @(negedge clk);
        sync_pulse();
        repeat (5) @(negedge clk);
        i2c_index = 8'h41;
        i2c_wdata = 8'h77;
        i2c_wr    = 1'b1;
        @(negedge clk);
        i2c_wr = 1'b0;
        wait_commit(lat);
        chk("commit2_latency", lat, 13);
        @(negedge clk);
        chk("active1_old", active_regs[15:8], 8'h33);
        chk("active18_last", active_regs[151:144], 8'hE7);
        peek(8'h41, v);
        chk("stage1_pending", v, 8'h77);
        chk("single_pend_no_oor", oor_err, 0);

        // Out-of-range write
        i2c_write(8'h60, 8'h12);
        @(negedge clk);
        chk("oor_set", oor_err, 1);
        peek(8'h60, v);
        chk("oor_read", v, 8'h00);
        peek(8'h42, v);
        chk("oor_no_change", v, 8'h3C);

        // Reset in COPY cycle 8
        i2c_write(8'h53, 8'hA5);
        repeat (3) @(negedge clk);
        sync_pulse();
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_active", (active_regs == '0), 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_oor", oor_err, 0);
        peek(8'h42, v);
        chk("midrst_stage", v, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (commit_done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        peek(8'h53, v);
        chk("midrst_idle", v, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pid_regbank_sequencer.md
Name: pid_regbank_sequencer

Overview:
- Register bank and access sequencer between the I2C slave RAM interface and the PID/BLDC core.
- Holds an 8-bit staging bank written by I2C or the core, and an active bank that feeds the PID datapath.
- Staging is copied into active only after an I2C commit-key write, followed by a core loop-boundary sync. The PID therefore never sees a half-updated coefficient set.

Parameters:
- BASE_ADDR, 8'h40, address of register 0.
- NUM_REGS, 20, total registers. Indices 0..NUM_REGS-2 are data; index NUM_REGS-1 (0x53) is the commit/control register.
- COMMIT_KEY, 8'hA5, value written to the control register to arm a commit.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset.
- i2c_wr, input, 1, write level from the I2C slave; may stay high for several cycles.
- i2c_index, input, 8, register address from the I2C slave.
- i2c_wdata, input, 8, write data from the I2C slave.
- i2c_rdata, output, 8, combinational read of staging[i2c_index].
- core_req, input, 1, core access request; held until granted.
- core_we, input, 1, 1 = write, 0 = read.
- core_addr, input, 8, core register address.
- core_wdata, input, 8, core write data.
- core_gnt, output, 1, one-cycle grant pulse.
- core_rdata, output, 8, registered read data, valid in the cycle core_gnt is high.
- core_sync, input, 1, PID loop-boundary pulse; a commit is allowed only here.
- active_regs, output, 8*(NUM_REGS-1), flattened active bank; register i occupies bits [8i+7:8i].
- busy, output, 1, high whenever state != IDLE.
- commit_done, output, 1, one-cycle pulse when a copy completes.
- oor_err, output, 1, sticky flag set by any out-of-range write.

Behaviour:
- Reset is synchronous and active-high (rst); the clock is clk.
  - Staging, active, control register, core_rdata, core_gnt, commit_done, busy, oor_err and the pending-write latch all clear to 0.
  - The internal i2c_wr edge register resets to 1, so a level already high at release does not trigger a write.
- Address decode: idx = addr - BASE_ADDR. An address is in range when BASE_ADDR <= addr <= BASE_ADDR+NUM_REGS-1.
  - Out-of-range read returns 8'h00.
  - Out-of-range write changes no register and sets oor_err.
- I2C write: only a rising edge of i2c_wr counts (edge register vs current level), committing exactly one write per edge.
  - The write lands in staging one cycle after the edge is detected.
  - i2c_rdata is purely combinational; the I2C slave samples it in the same cycle it raises its read strobe.
- Control register reads return {6'b0, state code}: IDLE=0, ARMED=1, COPY or DONE=2.
- Core port (IDLE or ARMED only):
  - With core_req high and no I2C write edge this cycle, core_gnt pulses the next cycle.
  - A write updates staging at the grant edge; a read drives core_rdata with that value.
  - A core write to the control register is ignored (no arm) and still granted.
- Simultaneous I2C write edge and core_req: I2C wins and the core is granted one cycle later. Back-to-back grants need core_req deasserted or re-sampled after each grant.
- FSM:
  - IDLE: an I2C write of COMMIT_KEY to the control register goes to ARMED. Any other value is stored and ignored.
  - ARMED: waits for core_sync. Staging writes are still accepted and are included in the commit. core_sync goes to COPY with copy index = 0.
  - COPY: copies active[idx] <= staging[idx], one register per cycle for idx = 0..NUM_REGS-2, i.e. NUM_REGS-1 cycles (19 at default). Then goes to DONE.
  - DONE: pulses commit_done, clears the control register to 0x00, applies any pending write, then returns to IDLE.
- During COPY and DONE:
  - core_req is not granted; the request stays pending.
  - One I2C write edge is latched (index and data) and applied in DONE.
  - A second edge during COPY overwrites the latch (last wins) and sets oor_err.
- core_sync in IDLE, COPY or DONE is ignored. A key re-write while ARMED stays ARMED.
- Reset in mid-COPY:
  - Both banks clear.
  - No commit_done is emitted.
  - The FSM returns to IDLE.
- Latencies:
  - Arm to commit_done: sync cycle + 19 COPY cycles + 1 DONE cycle.
  - active_regs stays unchanged outside COPY.

Test Plan:
- Reset, then I2C write 0x42 <= 8'h3C with i2c_wr held high 5 cycles -> staging[2] = 0x3C written exactly once; active_regs all zero; i2c_rdata at index 0x42 = 0x3C.
- Write 0x53 <= 0xA5, then pulse core_sync after 10 cycles -> busy high; active_regs[23:16] = 0x3C after 20 cycles; commit_done pulses once; control register reads 0x00.
- Write 0x53 <= 0x5A, then core_sync -> no copy; busy low; control register reads 0x00.
- Core read request of 0x42 in the same cycle as an I2C write edge to 0x45 -> I2C write lands first; core_gnt one cycle late with core_rdata = 0x3C.
- I2C write 0x41 <= 0x77 at COPY cycle 5 -> latched and applied in DONE; active[1] keeps its old value; staging[1] = 0x77 after DONE.
- I2C write to 0x60 -> no register change; oor_err = 1; i2c_rdata at 0x60 = 0x00.
- Assert rst in COPY cycle 8 -> all banks 0; state IDLE; no commit_done pulse.
